// File: rtl/irq_aggregator.sv
// -----------------------------------------------------------------------------
// irq_aggregator
// Avalon-MM interrupt aggregator for up to 16 sources. Each source is latched
// as level or rising-edge, masked, and combined into one registered irq to
// the CPU. ACTIVE_ID gives the lowest-index pending & enabled source.
//
// Optional build macro: IRQ_AGGREGATOR_SYNC_EN
//   defined   -> each irq_in bit passes a 2-flop synchronizer before use
//   undefined -> irq_in is used directly (all sources in the clk domain)
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   address     in   [2:0] register word address
//   chipselect  in   slave select
//   write_n     in   active-low write strobe (qualified by chipselect)
//   writedata   in   [15:0] write data
//   readdata    out  [15:0] registered read data (1-cycle latency)
//   irq_in      in   [NUM_SRC-1:0] source lines, bit 0 highest priority
//   irq         out  registered aggregate interrupt
//
// Register map: 0 PENDING (W1C, edge bits only), 1 MASK, 2 EDGE_SEL,
//               3 ACTIVE_ID (RO), 4 RAW (RO), 5-7 read 0.
// -----------------------------------------------------------------------------
module irq_aggregator #(
   parameter int          NUM_SRC    = 8,
   parameter logic [15:0] RESET_MASK = 16'h0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   input  logic [NUM_SRC-1:0] irq_in,
   output logic               irq
);

   // Bits at or above NUM_SRC are forced to zero everywhere via this mask.
   localparam logic [16:0] SRC_LIM  = (17'd1 << NUM_SRC) - 17'd1;
   localparam logic [15:0] SRC_MASK = SRC_LIM[15:0];

   // Lowest set bit index; scanning downward lets the lowest index win.
   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] id;
      id = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) begin
            id = i[3:0];
         end else begin
            id = id;
         end
      end
      return id;
   endfunction

   logic [15:0] r_pending;
   logic [15:0] r_mask;
   logic [15:0] r_edge_sel;
   logic [15:0] r_src_d;
   logic [15:0] r_rdata;
   logic        r_irq;

   logic [15:0] w_irq_ext;
   logic [15:0] w_src;
   logic        w_wr;
   logic        w_pend_wr;
   logic        w_mask_wr;
   logic        w_sel_wr;
   logic [15:0] w_rise;
   logic [15:0] w_pend_clr;
   logic [15:0] w_sel_chg;
   logic [15:0] w_pend_edge;
   logic [15:0] w_pend_mode;
   logic [15:0] w_pend_nxt;
   logic [15:0] w_act;
   logic [15:0] w_active_id;

   // Zero-extend the source lines to the full 16-bit register width.
   always_comb begin
      w_irq_ext = 16'h0000;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_irq_ext[i] = irq_in[i];
      end
   end

`ifdef IRQ_AGGREGATOR_SYNC_EN
   logic [15:0] r_sync1;
   logic [15:0] r_sync2;

   // Two-flop synchronizer for sources from foreign clock domains.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 16'h0000;
         r_sync2 <= 16'h0000;
      end else begin
         r_sync1 <= w_irq_ext;
         r_sync2 <= r_sync1;
      end
   end

   assign w_src = r_sync2;
`else
   assign w_src = w_irq_ext;
`endif

   assign w_wr      = chipselect & ~write_n;
   assign w_pend_wr = w_wr & (address == 3'd0);
   assign w_mask_wr = w_wr & (address == 3'd1);
   assign w_sel_wr  = w_wr & (address == 3'd2);

   assign w_rise     = w_src & ~r_src_d;
   assign w_pend_clr = w_pend_wr ? writedata : 16'h0000;
   // Bits whose mode flips this cycle keep their pending value for one cycle.
   assign w_sel_chg  = w_sel_wr ? ((writedata ^ r_edge_sel) & SRC_MASK) : 16'h0000;

   // Edge mode: a new edge beats a same-cycle W1C so no event is lost.
   assign w_pend_edge = w_rise | (r_pending & ~w_pend_clr);
   assign w_pend_mode = (r_edge_sel & w_pend_edge) | (~r_edge_sel & w_src);
   assign w_pend_nxt  = ((w_sel_chg & r_pending) | (~w_sel_chg & w_pend_mode)) & SRC_MASK;

   assign w_act       = r_pending & r_mask;
   assign w_active_id = (|w_act) ? {1'b1, 11'b000_0000_0000, lowest_set(w_act)} : 16'h0000;

   // Source history, pending latches and the software-visible config registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_src_d    <= 16'h0000;
         r_pending  <= 16'h0000;
         r_mask     <= RESET_MASK & SRC_MASK;
         r_edge_sel <= 16'h0000;
      end else begin
         r_src_d   <= w_src;
         r_pending <= w_pend_nxt;
         if (w_mask_wr) begin
            r_mask <= writedata & SRC_MASK;
         end
         if (w_sel_wr) begin
            r_edge_sel <= writedata & SRC_MASK;
         end
      end
   end

   // Registered read mux, updated every cycle regardless of chipselect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdata <= 16'h0000;
      end else begin
         case (address)
            3'd0:    r_rdata <= r_pending;
            3'd1:    r_rdata <= r_mask;
            3'd2:    r_rdata <= r_edge_sel;
            3'd3:    r_rdata <= w_active_id;
            3'd4:    r_rdata <= w_src & SRC_MASK;
            default: r_rdata <= 16'h0000;
         endcase
      end
   end

   // Aggregate interrupt, registered from the current pending and mask.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |w_act;
      end
   end

   assign readdata = r_rdata;
   assign irq      = r_irq;

endmodule
